// File: rtl/btc_host_responder.sv
//============================================================================
// Module      : btc_host_responder
// Description : Host-side responder for a byte-serial hash miner. It serves
//               message bytes from a 128 x 8 buffer on read requests and
//               collects the 32 hash bytes on write requests. It also
//               tracks the run of trailing zero bytes and the number of
//               bytes served.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module btc_host_responder (
    input  logic       clk,
    input  logic       rst_n,
    // miner side
    input  logic [7:0] m_uo,
    input  logic       m_rq,
    input  logic       m_done,
    output logic [7:0] m_ui,
    output logic       m_start,
    output logic       m_rdy,
    // message buffer load port
    input  logic       ld_we,
    input  logic [6:0] ld_addr,
    input  logic [7:0] ld_data,
    // job control / status
    input  logic       go,
    output logic       busy,
    output logic       result_valid,
    input  logic [4:0] res_addr,
    output logic [7:0] res_data,
    output logic [5:0] zero_run,
    output logic [7:0] serve_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SETUP = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;
    localparam logic [2:0] S_REL   = 3'd5;

    localparam logic [7:0] C_SERVE_MAX = 8'hFF;
    localparam logic [4:0] C_LAST_IDX  = 5'd31;

    logic [2:0] state_q;
    logic [2:0] state_d;

    logic [7:0] mem_q    [128];
    logic [7:0] result_q [32];

    logic [7:0] m_ui_q;
    logic [7:0] serve_cnt_q;
    logic [5:0] zero_run_q;
    logic [4:0] idx_q;
    logic       last_q;          // byte just stored was the final hash byte
    logic       result_valid_q;

    logic       w_rd_accept;
    logic       w_wr_accept;
    logic       w_job_accept;

    assign w_job_accept = (state_q == S_IDLE) && go;
    assign w_rd_accept  = (state_q == S_WAIT) && m_rq && !m_done;
    assign w_wr_accept  = (state_q == S_WAIT) && m_rq && m_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (w_rd_accept) begin
                    state_d = S_SETUP;
                end else if (w_wr_accept) begin
                    state_d = S_ACK;
                end
            end
            S_SETUP: state_d = S_ACK;
            S_ACK:   state_d = S_REL;
            S_REL: begin
                if (!m_rq) begin
                    state_d = last_q ? S_IDLE : S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe outputs decoded from the state alone so each pulse is exactly one cycle.
    always_comb begin
        m_start = 1'b0;
        m_rdy   = 1'b0;
        busy    = 1'b1;
        case (state_q)
            S_IDLE:  busy    = 1'b0;
            S_START: m_start = 1'b1;
            S_ACK:   m_rdy   = 1'b1;
            default: ;
        endcase
    end

    // Job datapath: served byte, counters, result index and completion flag.
    // The byte is fetched as the read request is accepted, so m_ui settles
    // during SETUP, a full cycle before m_rdy rises in ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ui_q         <= 8'h00;
            serve_cnt_q    <= 8'h00;
            zero_run_q     <= 6'd0;
            idx_q          <= 5'd0;
            last_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            if (w_job_accept) begin
                serve_cnt_q    <= 8'h00;
                zero_run_q     <= 6'd0;
                idx_q          <= 5'd0;
                last_q         <= 1'b0;
                result_valid_q <= 1'b0;
            end
            if (w_rd_accept) begin
                m_ui_q <= mem_q[m_uo[6:0]];
            end
            if ((state_q == S_SETUP) && (serve_cnt_q != C_SERVE_MAX)) begin
                serve_cnt_q <= serve_cnt_q + 8'd1;
            end
            if (w_wr_accept) begin
                zero_run_q <= (m_uo == 8'h00) ? (zero_run_q + 6'd1) : 6'd0;
                idx_q      <= idx_q + 5'd1;
                last_q     <= (idx_q == C_LAST_IDX);
            end
            if ((state_q == S_REL) && !m_rq && last_q) begin
                result_valid_q <= 1'b1;
            end
        end
    end

    // Storage arrays: deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (ld_we && (state_q == S_IDLE)) begin
            mem_q[ld_addr] <= ld_data;
        end
        if (w_wr_accept) begin
            result_q[idx_q] <= m_uo;
        end
    end

    assign m_ui         = m_ui_q;
    assign serve_cnt    = serve_cnt_q;
    assign zero_run     = zero_run_q;
    assign result_valid = result_valid_q;
    assign res_data     = result_q[res_addr];

endmodule

`default_nettype wire

// File: tb/tb_btc_host_responder.sv
//============================================================================
// Module      : tb_btc_host_responder
// Description : Scoreboard bench for btc_host_responder. A miner model
//               issues random read/write requests and queues the expected
//               acknowledge; a monitor checks every m_rdy edge against it.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_btc_host_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] m_uo;
    logic       m_rq;
    logic       m_done;
    logic [7:0] m_ui;
    logic       m_start;
    logic       m_rdy;
    logic       ld_we;
    logic [6:0] ld_addr;
    logic [7:0] ld_data;
    logic       go;
    logic       busy;
    logic       result_valid;
    logic [4:0] res_addr;
    logic [7:0] res_data;
    logic [5:0] zero_run;
    logic [7:0] serve_cnt;

    btc_host_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_uo         (m_uo),
        .m_rq         (m_rq),
        .m_done       (m_done),
        .m_ui         (m_ui),
        .m_start      (m_start),
        .m_rdy        (m_rdy),
        .ld_we        (ld_we),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .go           (go),
        .busy         (busy),
        .result_valid (result_valid),
        .res_addr     (res_addr),
        .res_data     (res_data),
        .zero_run     (zero_run),
        .serve_cnt    (serve_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_rd;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tb_mem  [128];
    logic [7:0] exp_res [32];
    logic [7:0] hash    [32];
    int n_checks   = 0;
    int n_pass     = 0;
    int start_cnt  = 0;
    int exp_starts = 0;
    int ack_cnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_evt(input string name, input string detail);
        n_checks++;
        $display("FAIL %s: %s", name, detail);
    endtask

    // Monitor: every rising m_rdy consumes one queued expectation.
    initial begin
        logic       prev_rdy;
        logic [7:0] prev_ui;
        bit         post;
        exp_t       cur;
        prev_rdy = 1'b0;
        prev_ui  = 8'h00;
        post     = 1'b0;
        cur.is_rd = 1'b0;
        cur.data  = 8'h00;
        forever begin
            @(negedge clk);
            if (post) begin
                chk("rdy_one_cycle", 32'(m_rdy), 32'd0);
                if (cur.is_rd) chk("ui_hold_after_ack", 32'(m_ui), 32'(cur.data));
                post = 1'b0;
            end
            if (m_start) start_cnt++;
            if (m_rdy && !prev_rdy) begin
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    fail_evt("unexpected_ack", "got m_rdy, expected no acknowledge");
                end else begin
                    cur  = exp_q.pop_front();
                    post = 1'b1;
                    if (cur.is_rd) begin
                        chk("ui_at_ack", 32'(m_ui), 32'(cur.data));
                        chk("ui_before_ack", 32'(prev_ui), 32'(cur.data));
                    end
                end
            end
            prev_rdy = m_rdy;
            prev_ui  = m_ui;
        end
    end

    // Miner model: one request, wait for the acknowledge, drop, then re-raise
    // as early as one cycle later.
    task automatic req(input bit wr, input logic [7:0] b);
        int   t;
        exp_t e;
        e.is_rd = !wr;
        e.data  = wr ? b : tb_mem[b[6:0]];
        exp_q.push_back(e);
        m_uo   = b;
        m_done = wr;
        m_rq   = 1'b1;
        t      = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!m_rdy && t < 64);
        if (!m_rdy) begin
            fail_evt("ack_timeout", "got no m_rdy, expected one within 64 cycles");
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        @(negedge clk);
        m_rq = 1'b0;
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic start_job();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        exp_starts++;
        chk("start_pulse", 32'(m_start), 32'd1);
        chk("busy_in_job", 32'(busy), 32'd1);
        @(negedge clk);
        chk("start_width", 32'(m_start), 32'd0);
    endtask

    task automatic write_hash(input int n);
        for (int k = 0; k < n; k++) begin
            req(1'b1, hash[k]);
            exp_res[k] = hash[k];
        end
    endtask

    function automatic int trailing_zeros();
        int c = 0;
        for (int k = 31; k >= 0; k--) begin
            if (hash[k] != 8'h00) break;
            c++;
        end
        return c;
    endfunction

    task automatic check_results();
        for (int k = 0; k < 32; k++) begin
            res_addr = 5'(k);
            #1;
            chk("res_data", 32'(res_data), 32'(exp_res[k]));
        end
    endtask

    task automatic end_job(input int nreads);
        chk("result_valid", 32'(result_valid), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("serve_cnt", 32'(serve_cnt), (nreads > 255) ? 32'd255 : 32'(nreads));
        chk("zero_run", 32'(zero_run), 32'(trailing_zeros()));
        check_results();
    endtask

    task automatic check_reset_vals();
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_m_rdy", 32'(m_rdy), 32'd0);
        chk("rst_m_ui", 32'(m_ui), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_serve_cnt", 32'(serve_cnt), 32'd0);
        chk("rst_zero_run", 32'(zero_run), 32'd0);
    endtask

    initial begin
        int acks;
        rst_n = 1'b0; m_uo = 8'h00; m_rq = 1'b0; m_done = 1'b0;
        ld_we = 1'b0; ld_addr = 7'd0; ld_data = 8'h00; go = 1'b0; res_addr = 5'd0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // Load mem[i] = i.
        for (int i = 0; i < 128; i++) begin
            ld_we = 1'b1; ld_addr = 7'(i); ld_data = 8'(i); tb_mem[i] = 8'(i);
            @(negedge clk);
        end
        ld_we = 1'b0;

        // Requests while idle are ignored.
        acks = ack_cnt;
        m_rq = 1'b1; m_uo = 8'h07;
        repeat (4) @(negedge clk);
        m_rq = 1'b0;
        chk("idle_rq_ignored", 32'(ack_cnt), 32'(acks));
        chk("idle_not_busy", 32'(busy), 32'd0);

        // Job A: address 5 first, blocked load and go while busy, 80 reads, A0..BF.
        start_job();
        req(1'b0, 8'h05);
        chk("serve_after_first", 32'(serve_cnt), 32'd1);
        ld_we = 1'b1; ld_addr = 7'd3; ld_data = 8'h55;
        @(negedge clk);
        ld_we = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int a = 1; a < 80; a++) req(1'b0, 8'(a));
        for (int k = 0; k < 32; k++) hash[k] = 8'hA0 + 8'(k);
        write_hash(32);
        @(negedge clk);
        end_job(80);
        chk("no_extra_start", 32'(start_cnt), 32'(exp_starts));

        // Job B: mem[3] must still hold 3; saturating serve count; 4 trailing zeros.
        start_job();
        req(1'b0, 8'h03);
        for (int i = 0; i < 299; i++) req(1'b0, 8'($urandom_range(0, 127)));
        for (int k = 0; k < 32; k++) hash[k] = (k < 28) ? 8'h11 : 8'h00;
        write_hash(32);
        @(negedge clk);
        end_job(300);

        // Job C: fresh random buffer; zeros except final byte.
        for (int i = 0; i < 128; i++) begin
            tb_mem[i] = 8'($urandom);
            ld_we = 1'b1; ld_addr = 7'(i); ld_data = tb_mem[i];
            @(negedge clk);
        end
        ld_we = 1'b0;
        start_job();
        for (int i = 0; i < 20; i++) req(1'b0, 8'($urandom_range(0, 127)));
        for (int k = 0; k < 32; k++) hash[k] = (k == 31) ? 8'h01 : 8'h00;
        write_hash(32);
        @(negedge clk);
        end_job(20);

        // Job D: reset after 10 hash bytes.
        start_job();
        for (int i = 0; i < 5; i++) req(1'b0, 8'($urandom_range(0, 127)));
        for (int k = 0; k < 32; k++) hash[k] = 8'($urandom);
        write_hash(10);
        rst_n = 1'b0;
        m_done = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals();
        chk("queue_empty_after_rst", 32'(exp_q.size()), 32'd0);
        check_results();

        // Job E: full random job after the reset.
        start_job();
        for (int i = 0; i < 40; i++) req(1'b0, 8'($urandom_range(0, 127)));
        for (int k = 0; k < 32; k++)
            hash[k] = ($urandom_range(0, 2) == 0 || k > 29) ? 8'h00 : 8'($urandom_range(1, 255));
        write_hash(32);
        @(negedge clk);
        end_job(40);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_start_count", 32'(start_cnt), 32'(exp_starts));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish within 2 ms");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/btc_host_responder.md
BTC_HOST_RESPONDER -- requirements
Module: btc_host_responder

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all logic on the rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have ports: m_uo  in  8  miner output bus; byte address {word[4:0],byte[1:0]} while reading, hash byte while writing.
REQ-004 SHALL have ports: m_rq  in  1  miner request strobe.
REQ-005 SHALL have ports: m_done  in  1  miner hash-complete flag, high through the whole write phase.
REQ-006 SHALL have ports: m_ui  out  8  data byte to the miner.
REQ-007 SHALL have ports: m_start  out  1  one-cycle job start pulse to the miner.
REQ-008 SHALL have ports: m_rdy  out  1  acknowledge strobe to the miner.
REQ-009 SHALL have ports: ld_we / ld_addr[6:0] / ld_data[7:0]  in  message-buffer write port, 128 x 8.
REQ-010 SHALL have ports: go  in  1  job request; busy  out  1; result_valid  out  1.
REQ-011 SHALL have ports: res_addr  in  5  and res_data  out  8  result byte read, combinational.
REQ-012 SHALL have ports: zero_run  out  6  count of consecutive 0x00 bytes ending at result byte 31.
REQ-013 SHALL have ports: serve_cnt  out  8  bytes served this job, saturating at 255.

Function
REQ-014 SHALL use states IDLE, START, WAIT, SETUP, ACK, REL.
REQ-015 IDLE: go=1 -> START; clears result_valid, serve_cnt, zero_run and result index; go in any other state SHALL be ignored.
REQ-016 START: m_start=1 for exactly one cycle -> WAIT; busy=1 in every state except IDLE.
REQ-017 WAIT, m_rq=1 and m_done=0 (read request): latch addr=m_uo[6:0] -> SETUP.
REQ-018 SETUP: m_ui <= mem[addr]; serve_cnt increments, saturating at 255 -> ACK; m_ui SHALL hold its value until the next SETUP.
REQ-019 WAIT, m_rq=1 and m_done=1 (write request): store m_uo into result[idx]; zero_run <= (m_uo==0) ? zero_run+1 : 0; idx increments -> ACK.
REQ-020 ACK: m_rdy=1 for exactly one cycle -> REL; m_rdy SHALL be 0 in every other state, so each acknowledge is a clean rising edge.
REQ-021 REL: stay until m_rq=0 is sampled, then WAIT; if the byte just stored was idx 31, SHALL go to IDLE and set result_valid=1 instead.
REQ-022 Data on m_ui SHALL be stable at least one cycle before the m_rdy rising edge and through the cycle after it.
REQ-023 ld_we SHALL write mem only while busy=0; writes while busy SHALL be dropped.
REQ-024 A read-request address of 128 or above is impossible because the width is 7 bits; no range check is required.
REQ-025 m_rq=1 in IDLE or START SHALL be ignored (no m_rdy).
REQ-026 idx SHALL be 5 bits and SHALL NOT wrap within a job, since termination occurs at 31.
REQ-027 result_valid SHALL stay high until the next accepted go.
REQ-028 res_data SHALL equal result[res_addr] at all times.

Reset
REQ-029 On rst_n=0 at any time, including mid-job: state=IDLE, m_start=0, m_rdy=0, m_ui=0, busy=0, result_valid=0, serve_cnt=0, zero_run=0, idx=0.
REQ-030 Reset SHALL NOT clear mem or the result buffer.

Verification
REQ-031 Load mem[i]=i, pulse go, miner model requests addr 0x05 -> m_ui=0x05 before the m_rdy edge; m_rdy high for exactly 1 cycle; serve_cnt=1.
REQ-032 Model requests addrs 0..79, then writes 32 hash bytes 0xA0..0xBF -> result[k]=0xA0+k; result_valid=1 after byte 31; busy=0; serve_cnt=80; zero_run=0.
REQ-033 Hash bytes 0..27 = 0x11 and bytes 28..31 = 0x00 -> zero_run=4; hash bytes 0x00 except byte 31=0x01 -> zero_run=0.
REQ-034 Model re-raises m_rq one cycle after dropping it -> exactly one m_rdy pulse per request, no missed and no duplicate acknowledges.
REQ-035 ld_we with 0x55 at addr 3 while busy -> mem[3] unchanged; go while busy -> no second m_start.
REQ-036 rst_n low during the write phase after 10 bytes -> all outputs at reset values; next go completes a full job normally.
